d_cache: RTL

//  Direct-mapped, write-through, no-write-allocate data cache between the pipelined CPU

---
 rtl/d_cache_pkg.sv | 20 ++
 rtl/d_cache_array.sv | 48 ++++
 rtl/d_cache.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/d_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM state encoding, default widths and the tag-width helper.
package d_cache_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_INDEX_W = 4;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2
    } state_t;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

endpackage

// File: rtl/d_cache_array.sv
// Line storage for d_cache: valid bits, tags and one data word per line.
// Asynchronous lookup read, synchronous fill/update write, single-cycle global invalidate.
module d_cache_array #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 12,
    parameter int DATA_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inval,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
        end else if (inval) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_index] <= 1'b1;
        end
    end

    // Tag and data contents need no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU data port
// and data memory; FSM, capture registers and saturating hit/miss counters.
module d_cache
    import d_cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              flush,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int TAG_W = tag_width(ADDR_W, INDEX_W);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [DATA_W-1:0] cap_data_reg;
    logic              cap_hit_reg;
    logic              done_reg, done_next;
    logic              flush_pend_reg, flush_pend_next;
    logic [CNT_W-1:0]  hit_count_reg, miss_count_reg;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              lookup_hit, write_done;
    logic              arr_wr_en, inval, capture, hit_inc, miss_inc;
    logic [DATA_W-1:0] arr_wr_data;

    assign lookup_hit  = rd_valid && (rd_tag == cpu_addr[ADDR_W-1:INDEX_W]);
    // A completed write stays "done" while the CPU keeps presenting it, so it is not reissued.
    assign write_done  = done_reg && cpu_req && cpu_we && (cpu_addr == cap_addr_reg);
    assign done_next   = ((state_reg == ST_WR_THRU) && mem_ready) || write_done;
    assign flush_pend_next = (state_reg != ST_IDLE) ? (flush_pend_reg || flush) : 1'b0;
    assign arr_wr_data = (state_reg == ST_RD_MISS) ? mem_rdata : cap_data_reg;

    d_cache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .inval    (inval),
        .rd_index (cpu_addr[INDEX_W-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (arr_wr_en),
        .wr_index (cap_addr_reg[INDEX_W-1:0]),
        .wr_tag   (cap_addr_reg[ADDR_W-1:INDEX_W]),
        .wr_data  (arr_wr_data)
    );

    always_comb begin
        state_next = state_reg;
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        arr_wr_en  = 1'b0;
        inval      = 1'b0;
        capture    = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        if (reset) begin
            case (state_reg)
                ST_IDLE: begin
                    if (flush || flush_pend_reg) begin
                        inval     = 1'b1;
                        cpu_stall = 1'b1;
                    end else if (cpu_req) begin
                        if (cpu_we) begin
                            if (!write_done) begin
                                cpu_stall  = 1'b1;
                                capture    = 1'b1;
                                state_next = ST_WR_THRU;
                            end
                        end else if (lookup_hit) begin
                            cpu_rdata = rd_data;
                            hit_inc   = 1'b1;
                        end else begin
                            cpu_stall  = 1'b1;
                            capture    = 1'b1;
                            miss_inc   = 1'b1;
                            state_next = ST_RD_MISS;
                        end
                    end
                end
                ST_RD_MISS: begin
                    mem_rd    = 1'b1;
                    cpu_stall = 1'b1;
                    if (mem_ready) begin
                        arr_wr_en  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_WR_THRU: begin
                    mem_wr    = 1'b1;
                    cpu_stall = 1'b1;
                    if (mem_ready) begin
                        arr_wr_en  = cap_hit_reg;
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            cap_addr_reg   <= '0;
            cap_data_reg   <= '0;
            cap_hit_reg    <= 1'b0;
            done_reg       <= 1'b0;
            flush_pend_reg <= 1'b0;
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            done_reg       <= done_next;
            flush_pend_reg <= flush_pend_next;
            if (capture) begin
                cap_addr_reg <= cpu_addr;
                cap_data_reg <= cpu_wdata;
                cap_hit_reg  <= lookup_hit;
            end
            if (hit_inc && (hit_count_reg != {CNT_W{1'b1}}))
                hit_count_reg <= hit_count_reg + CNT_W'(1);
            if (miss_inc && (miss_count_reg != {CNT_W{1'b1}}))
                miss_count_reg <= miss_count_reg + CNT_W'(1);
        end
    end

    assign mem_addr   = cap_addr_reg;
    assign mem_wdata  = cap_data_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

endmodule
